// File: rtl/pixel_scan_ctrl.sv
// rtl/pixel_scan_ctrl.sv - raster pixel issuer with fixed-latency shader return buffer
// Optional build macro: PIXEL_SCAN_CONTINUOUS_EN (re-scan frames back to back without start)
module pixel_scan_ctrl #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int PIPE_LAT   = 8,
   parameter int FIFO_DEPTH = 16,
   localparam int CORDW     = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             frame_done,
   output logic [CORDW-1:0] scan_x,
   output logic [CORDW-1:0] scan_y,
   output logic             scan_valid,
   input  logic [7:0]       shade_red,
   input  logic [7:0]       shade_green,
   input  logic [7:0]       shade_blue,
   output logic [CORDW-1:0] out_x,
   output logic [CORDW-1:0] out_y,
   output logic [7:0]       out_red,
   output logic [7:0]       out_green,
   output logic [7:0]       out_blue,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int EW   = 2 * CORDW + 24;
   localparam logic [CORDW-1:0] X_LAST  = CORDW'(H_RES - 1);
   localparam logic [CORDW-1:0] Y_LAST  = CORDW'(V_RES - 1);
   localparam logic [CNTW:0]    DEPTH_C = (CNTW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

   state_t           state;
   logic [CORDW-1:0] x, y;
   logic [CNTW-1:0]  in_flight, fifo_count;
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [PIPE_LAT-1:0] dl_v;
   logic [CORDW-1:0] dl_x [PIPE_LAT];
   logic [CORDW-1:0] dl_y [PIPE_LAT];
   logic [EW-1:0]    mem [FIFO_DEPTH];
   logic [EW-1:0]    head;
   logic             issue, ret, push, pop, last_pop;

   // in_flight counts pixels committed at the issue decision, so the budget also
   // covers the pixel that appears on scan_valid one cycle later
   assign issue    = (state == S_SCAN) &&
                     (({1'b0, in_flight} + {1'b0, fifo_count}) < DEPTH_C);
   assign ret      = dl_v[PIPE_LAT-1];
   assign push     = ret;
   assign pop      = out_valid && out_ready;
   assign last_pop = pop && !push && (fifo_count == CNTW'(1)) && (in_flight == '0);

   assign busy      = (state != S_IDLE);
   assign out_valid = (fifo_count != '0);
   assign head      = mem[rd_ptr];
   assign out_x     = out_valid ? head[EW-1 -: CORDW]          : '0;
   assign out_y     = out_valid ? head[EW-CORDW-1 -: CORDW]    : '0;
   assign out_red   = out_valid ? head[23:16]                  : '0;
   assign out_green = out_valid ? head[15:8]                   : '0;
   assign out_blue  = out_valid ? head[7:0]                    : '0;
   assign out_sof   = out_valid && (out_x == '0) && (out_y == '0);
   assign out_eol   = out_valid && (out_x == X_LAST);

   // Frame sequencing, raster counters and registered scan outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         x          <= '0;
         y          <= '0;
         scan_x     <= '0;
         scan_y     <= '0;
         scan_valid <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         scan_valid <= issue;
         if (issue) begin
            scan_x <= x;
            scan_y <= y;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_SCAN;
                  x     <= '0;
                  y     <= '0;
               end
            end
            S_SCAN: begin
               if (issue) begin
                  if (x == X_LAST) begin
                     x <= '0;
                     if (y == Y_LAST) begin
                        y     <= '0;
                        state <= S_DRAIN;
                     end else begin
                        y <= y + 1'b1;
                     end
                  end else begin
                     x <= x + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               if (last_pop) begin
                  frame_done <= 1'b1;
`ifdef PIXEL_SCAN_CONTINUOUS_EN
                  state <= S_SCAN;
                  x     <= '0;
                  y     <= '0;
`else
                  state <= S_IDLE;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Valid bits of the shader delay line; stage PIPE_LAT-1 lines up with the returning colour
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_v <= '0;
      end else begin
         dl_v[0] <= scan_valid;
         for (int i = 1; i < PIPE_LAT; i++) dl_v[i] <= dl_v[i-1];
      end
   end

   // Coordinates travel alongside the valid bits; they need no reset
   always_ff @(posedge clk) begin
      dl_x[0] <= scan_x;
      dl_y[0] <= scan_y;
      for (int i = 1; i < PIPE_LAT; i++) begin
         dl_x[i] <= dl_x[i-1];
         dl_y[i] <= dl_y[i-1];
      end
   end

   // Outstanding shader requests and return buffer occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_flight  <= '0;
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         case ({issue, ret})
            2'b10:   in_flight <= in_flight + 1'b1;
            2'b01:   in_flight <= in_flight - 1'b1;
            default: in_flight <= in_flight;
         endcase
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Return buffer storage, written with the colour in the cycle it arrives
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {dl_x[PIPE_LAT-1], dl_y[PIPE_LAT-1], shade_red, shade_green, shade_blue};
      end
   end

endmodule

// File: doc/pixel_scan_ctrl.md
PIXEL_SCAN_CTRL -- requirements
Module: pixel_scan_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, meaning lines per frame.
REQ-003 SHALL have parameter PIPE_LAT, default 8, meaning fixed cycles from scan coordinate to valid shade colour (range 1..63).
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning return-buffer entries (power of 2, at least 2).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: frame request pulse.
REQ-008 SHALL have ports busy and frame_done, outputs, 1 bit each: frame in progress; one-cycle frame-complete pulse.
REQ-009 SHALL have ports scan_x and scan_y, outputs, 10 bits each (CORDW): coordinates driven to the shader.
REQ-010 SHALL have port scan_valid, output, 1 bit: scan_x/scan_y carry a new issued pixel this cycle.
REQ-011 SHALL have ports shade_red, shade_green and shade_blue, inputs, 8 bits each: shader colour, valid PIPE_LAT cycles after issue.
REQ-012 SHALL have ports out_x and out_y, outputs, 10 bits each: coordinates of the buffered pixel.
REQ-013 SHALL have ports out_red, out_green and out_blue, outputs, 8 bits each: colour of the buffered pixel.
REQ-014 SHALL have ports out_sof and out_eol, outputs, 1 bit each: pixel (0,0); pixel x==H_RES-1.
REQ-015 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: downstream handshake.

Function
REQ-016 SHALL implement FSM IDLE -> SCAN -> DRAIN -> IDLE, with busy=1 in SCAN and DRAIN.
REQ-017 SHALL, in IDLE, move to SCAN on start=1, with x=y=0; start SHALL be ignored in SCAN and DRAIN.
REQ-018 SHALL issue in SCAN (scan_valid=1) only when in_flight+fifo_count < FIFO_DEPTH; the FIFO can therefore never overflow.
REQ-019 SHALL advance on issue in raster order: x++; at x==H_RES-1, x wraps to 0 and y++; issuing (H_RES-1,V_RES-1) moves the FSM to DRAIN.
REQ-020 SHALL hold scan_x/scan_y at their last values when scan_valid=0.
REQ-021 SHALL carry issued coordinates through a PIPE_LAT-deep valid/coordinate delay line and, when its output is valid, write {x,y,shade_*} into the FIFO in the same cycle.
REQ-022 SHALL leave in_flight unchanged on a simultaneous issue and return; in_flight +1 on issue only; -1 on return only.
REQ-023 SHALL drive out_* from the FIFO head with out_valid=!empty; the head pops when out_valid&&out_ready; simultaneous push and pop SHALL keep the count.
REQ-024 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL leave DRAIN when in_flight==0 and the FIFO is empty after the last pop, pulsing frame_done for 1 cycle and entering IDLE.
REQ-026 SHALL keep the issue-to-FIFO-write latency exactly PIPE_LAT cycles, with FIFO write-to-out_valid at most 1 cycle.

Reset
REQ-027 SHALL, on rst=1, immediately clear state to IDLE and zero x, y, in_flight, the FIFO pointers/count and the delay-line valids.
REQ-028 SHALL hold all outputs (busy, frame_done, scan_*, out_*) at 0 during reset.
REQ-029 SHALL treat reset mid-frame as discarding all in-flight and buffered pixels, with no frame_done emitted.

Configuration
REQ-030 SHALL, with PIXEL_SCAN_CONTINUOUS_EN defined, go from DRAIN straight to SCAN with x=y=0 after the frame_done pulse, no start needed, until rst.
REQ-031 SHALL, without PIXEL_SCAN_CONTINUOUS_EN, return to IDLE and wait for start.

Verification (H_RES=4, V_RES=3, PIPE_LAT=3, FIFO_DEPTH=4; shader model returns red=x, green=y, blue=0xA5 delayed 3 cycles)
REQ-032 SHALL cover: start, out_ready=1 -> 12 pixels out in raster order, out_red==out_x, out_green==out_y, sof only at (0,0), eol at x=3, one frame_done pulse after 12th pop.
REQ-033 SHALL cover: start, out_ready=0 -> exactly 4 scan_valid pulses then none; out_* stable; release out_ready -> all 12 pixels in order, none lost or duplicated.
REQ-034 SHALL cover: start pulsed again at pixel 5 -> no restart; sequence unchanged; one frame_done.
REQ-035 SHALL cover: rst asserted after 6 pops -> next cycle busy=0, out_valid=0, scan_valid=0; new start -> clean frame from (0,0).
REQ-036 SHALL cover: out_ready toggling 1/0 every cycle -> 12 correct pixels; in_flight+fifo_count never exceeds 4.
REQ-037 SHALL cover: PIXEL_SCAN_CONTINUOUS_EN, single start -> 3 consecutive frames, 3 frame_done pulses, busy=0 for no cycle between them.
